// File: rtl/nibble_pack_pkg.sv
// Shared constants and FSM state type for the nibble packer.
package nibble_pack_pkg;

  localparam int unsigned NIB_W_DEF = 4;
  localparam int unsigned NIBS_DEF  = 4;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } pack_state_t;

endpackage

// File: rtl/pack_out_reg.sv
// Output holding stage: presents a completed word with valid/ready handshake.
module pack_out_reg
  import nibble_pack_pkg::*;
#(
  parameter int unsigned WW = NIB_W_DEF * NIBS_DEF,
  parameter int unsigned CW = $clog2(NIBS_DEF + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_load,
  input  logic [WW-1:0] i_word,
  input  logic [CW-1:0] i_cnt,
  input  logic          out_ready,
  output logic          out_valid,
  output logic [WW-1:0] out_word,
  output logic [CW-1:0] out_cnt,
  output logic          o_can_load
);

  logic          r_valid;
  logic [WW-1:0] r_word;
  logic [CW-1:0] r_cnt;

  // A new word may enter when the stage is empty or being drained this cycle.
  assign o_can_load = !r_valid || out_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid <= 1'b0;
      r_word  <= '0;
      r_cnt   <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_word  <= i_word;
      r_cnt   <= i_cnt;
    end else if (r_valid && out_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign out_valid = r_valid;
  assign out_word  = r_word;
  assign out_cnt   = r_cnt;

endmodule

// File: rtl/nibble_packer.sv
// Packs a stream of nibbles into words, closing early on in_last; zero-fills
// the unused upper nibbles and reports the valid nibble count.
module nibble_packer
  import nibble_pack_pkg::*;
#(
  parameter int unsigned NIB_W = NIB_W_DEF,
  parameter int unsigned NIBS  = NIBS_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [NIB_W-1:0]           in_nib,
  input  logic                       in_last,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [NIB_W*NIBS-1:0]      out_word,
  output logic [$clog2(NIBS+1)-1:0]  out_cnt
);

  localparam int unsigned WW = NIB_W * NIBS;
  localparam int unsigned CW = $clog2(NIBS + 1);
  localparam logic [CW-1:0] LAST_POS = CW'(NIBS - 1);

  pack_state_t   r_state, w_state_next;
  logic [WW-1:0] r_asm, w_asm_next, w_ld_word;
  logic [CW-1:0] r_cnt, w_cnt_next, w_ld_cnt;
  logic          w_accept, w_complete, w_can_load, w_load, w_clear;

  assign in_ready   = (r_state == FILL);
  assign w_accept   = in_valid && in_ready;
  assign w_complete = w_accept && (in_last || (r_cnt == LAST_POS));
  assign w_cnt_next = r_cnt + CW'(1);

  // The assembly register is cleared after each word, so untouched slots stay zero.
  always_comb begin
    w_asm_next = r_asm;
    for (int unsigned k = 0; k < NIBS; k++) begin
      if (r_cnt == CW'(k)) w_asm_next[k*NIB_W +: NIB_W] = in_nib;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_clear      = 1'b0;
    w_ld_word    = w_asm_next;
    w_ld_cnt     = w_cnt_next;
    case (r_state)
      FILL: begin
        if (w_complete) begin
          if (w_can_load) begin
            w_load  = 1'b1;
            w_clear = 1'b1;
          end else begin
            w_state_next = HOLD;
          end
        end
      end
      HOLD: begin
        w_ld_word = r_asm;
        w_ld_cnt  = r_cnt;
        if (out_ready) begin
          w_load       = 1'b1;
          w_clear      = 1'b1;
          w_state_next = FILL;
        end
      end
      default: w_state_next = FILL;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= FILL;
      r_asm   <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_clear) begin
        r_asm <= '0;
        r_cnt <= '0;
      end else if (w_accept) begin
        r_asm <= w_asm_next;
        r_cnt <= w_cnt_next;
      end
    end
  end

  pack_out_reg #(
    .WW (WW),
    .CW (CW)
  ) u_out_reg (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_load),
    .i_word     (w_ld_word),
    .i_cnt      (w_ld_cnt),
    .out_ready  (out_ready),
    .out_valid  (out_valid),
    .out_word   (out_word),
    .out_cnt    (out_cnt),
    .o_can_load (w_can_load)
  );

endmodule

// File: tb/tb_nibble_packer.sv
// Directed, table-driven bench for nibble_packer (NIB_W=4, NIBS=4).
module tb_nibble_packer;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_nib;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_word;
  logic [2:0]  out_cnt;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        v;
    logic [3:0]  nib;
    logic        last;
    logic        ordy;
    logic        e_irdy;
    logic        e_ov;
    logic [15:0] e_word;
    logic [2:0]  e_cnt;
  } vec_t;

  vec_t tbl[$];

  nibble_packer #(
    .NIB_W (4),
    .NIBS  (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_nib    (in_nib),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_word  (out_word),
    .out_cnt   (out_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(logic v, logic [3:0] nib, logic last, logic ordy,
                              logic e_irdy, logic e_ov, logic [15:0] e_word, logic [2:0] e_cnt);
    vec_t r;
    r.v = v; r.nib = nib; r.last = last; r.ordy = ordy;
    r.e_irdy = e_irdy; r.e_ov = e_ov; r.e_word = e_word; r.e_cnt = e_cnt;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic v, input logic [3:0] nib, input logic last, input logic ordy);
    in_valid  = v;
    in_nib    = nib;
    in_last   = last;
    out_ready = ordy;
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input logic e_irdy, input logic e_ov,
                           input logic [15:0] e_word, input logic [2:0] e_cnt);
    check({tag, ".in_ready"}, 32'(in_ready), 32'(e_irdy));
    check({tag, ".out_valid"}, 32'(out_valid), 32'(e_ov));
    if (e_ov) begin
      check({tag, ".out_word"}, 32'(out_word), 32'(e_word));
      check({tag, ".out_cnt"}, 32'(out_cnt), 32'(e_cnt));
    end
  endtask

  initial begin
    // Full word 0x4321 with consumer always ready.
    tbl.push_back(mk(1, 4'h1, 0, 1, 1, 0, 16'h0000, 3'd0));
    tbl.push_back(mk(1, 4'h2, 0, 1, 1, 0, 16'h0000, 3'd0));
    tbl.push_back(mk(1, 4'h3, 0, 1, 1, 0, 16'h0000, 3'd0));
    tbl.push_back(mk(1, 4'h4, 0, 1, 1, 1, 16'h4321, 3'd4));
    // Early close 0x00BA, then a one-nibble word loaded while draining.
    tbl.push_back(mk(1, 4'hA, 0, 1, 1, 0, 16'h0000, 3'd0));
    tbl.push_back(mk(1, 4'hB, 1, 1, 1, 1, 16'h00BA, 3'd2));
    tbl.push_back(mk(1, 4'h7, 1, 1, 1, 1, 16'h0007, 3'd1));
    tbl.push_back(mk(0, 4'h0, 0, 1, 1, 0, 16'h0000, 3'd0));
    // in_last on the final slot: one full word, no empty word after.
    tbl.push_back(mk(1, 4'hF, 0, 1, 1, 0, 16'h0000, 3'd0));
    tbl.push_back(mk(1, 4'hE, 0, 1, 1, 0, 16'h0000, 3'd0));
    tbl.push_back(mk(1, 4'hD, 0, 1, 1, 0, 16'h0000, 3'd0));
    tbl.push_back(mk(1, 4'hC, 1, 1, 1, 1, 16'hCDEF, 3'd4));
    tbl.push_back(mk(0, 4'h0, 0, 1, 1, 0, 16'h0000, 3'd0));
    tbl.push_back(mk(0, 4'h0, 0, 1, 1, 0, 16'h0000, 3'd0));
    // Back-pressure: second word is held, input stalls, nibble 0x9 ignored.
    tbl.push_back(mk(1, 4'h1, 0, 0, 1, 0, 16'h0000, 3'd0));
    tbl.push_back(mk(1, 4'h2, 0, 0, 1, 0, 16'h0000, 3'd0));
    tbl.push_back(mk(1, 4'h3, 0, 0, 1, 0, 16'h0000, 3'd0));
    tbl.push_back(mk(1, 4'h4, 0, 0, 1, 1, 16'h4321, 3'd4));
    tbl.push_back(mk(1, 4'h5, 0, 0, 1, 1, 16'h4321, 3'd4));
    tbl.push_back(mk(1, 4'h6, 0, 0, 1, 1, 16'h4321, 3'd4));
    tbl.push_back(mk(1, 4'h7, 0, 0, 1, 1, 16'h4321, 3'd4));
    tbl.push_back(mk(1, 4'h8, 0, 0, 0, 1, 16'h4321, 3'd4));
    tbl.push_back(mk(1, 4'h9, 0, 0, 0, 1, 16'h4321, 3'd4));
    tbl.push_back(mk(0, 4'h0, 0, 1, 1, 1, 16'h8765, 3'd4));
    tbl.push_back(mk(0, 4'h0, 0, 1, 1, 0, 16'h0000, 3'd0));
    // Drain and load on the same edge: in_ready never drops.
    tbl.push_back(mk(1, 4'h1, 0, 0, 1, 0, 16'h0000, 3'd0));
    tbl.push_back(mk(1, 4'h2, 0, 0, 1, 0, 16'h0000, 3'd0));
    tbl.push_back(mk(1, 4'h3, 0, 0, 1, 0, 16'h0000, 3'd0));
    tbl.push_back(mk(1, 4'h4, 0, 0, 1, 1, 16'h4321, 3'd4));
    tbl.push_back(mk(1, 4'h5, 0, 0, 1, 1, 16'h4321, 3'd4));
    tbl.push_back(mk(1, 4'h6, 0, 0, 1, 1, 16'h4321, 3'd4));
    tbl.push_back(mk(1, 4'h7, 0, 0, 1, 1, 16'h4321, 3'd4));
    tbl.push_back(mk(1, 4'h8, 0, 1, 1, 1, 16'h8765, 3'd4));
    tbl.push_back(mk(0, 4'h0, 0, 1, 1, 0, 16'h0000, 3'd0));

    rst       = 1'b0;
    in_valid  = 1'b0;
    in_nib    = '0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset.out_valid", 32'(out_valid), 32'd0);
    check("reset.out_word", 32'(out_word), 32'd0);
    check("reset.out_cnt", 32'(out_cnt), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("reset.in_ready", 32'(in_ready), 32'd1);

    foreach (tbl[i]) begin
      step(tbl[i].v, tbl[i].nib, tbl[i].last, tbl[i].ordy);
      check_out($sformatf("vec%0d", i), tbl[i].e_irdy, tbl[i].e_ov, tbl[i].e_word, tbl[i].e_cnt);
    end

    // Reset after a partial word; out_word holds a stale 0x8765 beforehand.
    step(1, 4'h1, 0, 1);
    step(1, 4'h2, 0, 1);
    rst = 1'b0;
    #1;
    check("midrst.out_valid", 32'(out_valid), 32'd0);
    check("midrst.out_word", 32'(out_word), 32'd0);
    check("midrst.out_cnt", 32'(out_cnt), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    step(1, 4'h5, 0, 1);
    check_out("midrst.n5", 1, 0, 16'h0, 3'd0);
    step(1, 4'h6, 0, 1);
    step(1, 4'h7, 0, 1);
    step(1, 4'h8, 0, 1);
    check_out("midrst.word", 1, 1, 16'h8765, 3'd4);
    step(0, 4'h0, 0, 1);

    // Reset while a word is held in HOLD: both words discarded.
    for (int k = 1; k <= 8; k++) step(1, 4'(k), 0, 0);
    check_out("holdrst.pre", 0, 1, 16'h4321, 3'd4);
    rst = 1'b0;
    #1;
    check("holdrst.in_ready", 32'(in_ready), 32'd1);
    check("holdrst.out_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    step(1, 4'hA, 1, 1);
    check_out("holdrst.word", 1, 1, 16'h000A, 3'd1);
    step(0, 4'h0, 0, 1);
    check_out("holdrst.drain", 1, 0, 16'h0, 3'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
